// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_stall_ctrl_pkg;

    localparam int REG_W = 3;

    // Instruction word loaded into IF/ID when it is flushed.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Drain counter value whose increment marks HALT leaving WB.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hsc_state_e;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    // RAW match of the ID sources against one stage; when need_ld is set
    // the match only counts if that stage holds a load.
    function automatic logic stage_hit(
        input sb_entry_t        e,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             rs_used,
        input logic             rt_used,
        input logic             need_ld
    );
        logic src_match;
        src_match = (rs_used && (rs == e.rd)) || (rt_used && (rt == e.rd));
        return e.v && e.wr && src_match && (!need_ld || e.ld);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sb.sv
// Single scoreboard stage: clears on reset, freezes on hold, else loads
// either a bubble or the incoming entry.
module hazard_sb_entry
    import hazard_stall_ctrl_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      hold_i,
    input  logic      bubble_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    sb_entry_t entry_q;

    // Stage register with hold taking priority over bubble/load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else if (!hold_i) begin
            entry_q <= bubble_i ? sb_entry_t'('0) : d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: decides advance/hold/flush/bubble for the
// front of the 5-stage core, tracks in-flight writers, and drains on HALT.
//
// state   | meaning
// RUN     | normal issue; stalls, redirects and memory freezes handled
// DRAIN   | HALT issued; younger work discarded while older work retires
// HALTED  | pipe empty; everything frozen until reset
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int RF_BYPASS  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [2:0]       id_rs_i,
    input  logic [2:0]       id_rt_i,
    input  logic             id_rs_used_i,
    input  logic             id_rt_used_i,
    input  logic             id_regwrt_i,
    input  logic [2:0]       id_rd_i,
    input  logic             id_memread_i,
    input  logic             id_halt_i,
    input  logic             ex_redirect_i,
    input  logic             mem_stall_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_valid_o,
    output logic             pipe_we_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hsc_state_e       state_q;
    logic [1:0]       drain_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t sb_ex_d;

    logic hit_ex, hit_mem, hit_wb, hit_ex_ld;
    logic hz, advance;

    assign hit_ex    = stage_hit(sb_ex_q,  id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, 1'b0);
    assign hit_ex_ld = stage_hit(sb_ex_q,  id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, 1'b1);
    assign hit_mem   = stage_hit(sb_mem_q, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, 1'b0);
    assign hit_wb    = stage_hit(sb_wb_q,  id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, 1'b0);

    // With forwarding only a load in EX cannot be bypassed in time; without
    // it every older writer blocks, except WB when the RF writes first.
    generate
        if (FORWARDING != 0) begin : g_fwd
            assign hz = id_valid_i && hit_ex_ld;
        end else begin : g_nofwd
            assign hz = id_valid_i && (hit_ex || hit_mem || (hit_wb && (RF_BYPASS == 0)));
        end
    endgenerate

    assign advance = (state_q == ST_RUN) && !mem_stall_i && !ex_redirect_i && !hz;

    assign sb_ex_d = '{v: id_valid_i, wr: id_regwrt_i, rd: id_rd_i, ld: id_memread_i};

    hazard_sb_entry u_sb_ex (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (mem_stall_i),
        .bubble_i (!advance),
        .d_i      (sb_ex_d),
        .q_o      (sb_ex_q)
    );

    hazard_sb_entry u_sb_mem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (mem_stall_i),
        .bubble_i (1'b0),
        .d_i      (sb_ex_q),
        .q_o      (sb_mem_q)
    );

    hazard_sb_entry u_sb_wb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (mem_stall_i),
        .bubble_i (1'b0),
        .d_i      (sb_mem_q),
        .q_o      (sb_wb_q)
    );

    // Sequencing FSM, drain counter and saturating hazard-stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!mem_stall_i && !ex_redirect_i) begin
                        if (hz) begin
                            if (stall_cnt_q != '1) begin
                                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                            end
                        end else if (id_valid_i && id_halt_i) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!mem_stall_i) begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_q <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Latch enables react to this cycle's hazards, so they are decoded from
    // the state and live inputs; reset forces everything off.
    always_comb begin
        pc_we_o      = 1'b0;
        ifid_we_o    = 1'b0;
        ifid_flush_o = 1'b0;
        idex_valid_o = 1'b0;
        pipe_we_o    = 1'b0;
        halted_o     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall_i) begin
                        pipe_we_o = 1'b0;
                    end else if (ex_redirect_i) begin
                        pc_we_o      = 1'b1;
                        ifid_we_o    = 1'b1;
                        ifid_flush_o = 1'b1;
                        pipe_we_o    = 1'b1;
                    end else if (hz) begin
                        pipe_we_o = 1'b1;
                    end else begin
                        pc_we_o      = 1'b1;
                        ifid_we_o    = 1'b1;
                        idex_valid_o = id_valid_i;
                        pipe_we_o    = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ifid_flush_o = 1'b1;
                    ifid_we_o    = !mem_stall_i;
                    pipe_we_o    = !mem_stall_i;
                end
                ST_HALTED: begin
                    halted_o = 1'b1;
                end
                default: begin
                    halted_o = 1'b0;
                end
            endcase
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one forwarding instance and one
// non-forwarding (RF bypass) instance driven from the same inputs.
module tb_hazard_stall_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i, id_rs_used_i, id_rt_used_i, id_regwrt_i;
    logic       id_memread_i, id_halt_i, ex_redirect_i, mem_stall_i;
    logic [2:0] id_rs_i, id_rt_i, id_rd_i;

    logic        f_pc_we, f_ifid_we, f_ifid_flush, f_idex_valid, f_pipe_we, f_halted;
    logic        n_pc_we, n_ifid_we, n_ifid_flush, n_idex_valid, n_pipe_we, n_halted;
    logic [15:0] f_cnt, n_cnt;
    logic [5:0]  f_out, n_out;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_we, ifid_we, ifid_flush, idex_valid, pipe_we, halted}
    assign f_out = {f_pc_we, f_ifid_we, f_ifid_flush, f_idex_valid, f_pipe_we, f_halted};
    assign n_out = {n_pc_we, n_ifid_we, n_ifid_flush, n_idex_valid, n_pipe_we, n_halted};

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl #(.FORWARDING(1), .RF_BYPASS(1), .CNT_W(16)) u_fwd (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_regwrt_i(id_regwrt_i), .id_rd_i(id_rd_i), .id_memread_i(id_memread_i),
        .id_halt_i(id_halt_i), .ex_redirect_i(ex_redirect_i), .mem_stall_i(mem_stall_i),
        .pc_we_o(f_pc_we), .ifid_we_o(f_ifid_we), .ifid_flush_o(f_ifid_flush),
        .idex_valid_o(f_idex_valid), .pipe_we_o(f_pipe_we), .halted_o(f_halted),
        .stall_cnt_o(f_cnt)
    );

    hazard_stall_ctrl #(.FORWARDING(0), .RF_BYPASS(1), .CNT_W(16)) u_nofwd (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_regwrt_i(id_regwrt_i), .id_rd_i(id_rd_i), .id_memread_i(id_memread_i),
        .id_halt_i(id_halt_i), .ex_redirect_i(ex_redirect_i), .mem_stall_i(mem_stall_i),
        .pc_we_o(n_pc_we), .ifid_we_o(n_ifid_we), .ifid_flush_o(n_ifid_flush),
        .idex_valid_o(n_idex_valid), .pipe_we_o(n_pipe_we), .halted_o(n_halted),
        .stall_cnt_o(n_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic wr,
                          input logic [2:0] rd, input logic ld, input logic halt);
        id_valid_i   = v;
        id_rs_i      = rs;
        id_rs_used_i = rsu;
        id_rt_i      = rt;
        id_rt_used_i = rtu;
        id_regwrt_i  = wr;
        id_rd_i      = rd;
        id_memread_i = ld;
        id_halt_i    = halt;
    endtask

    task automatic id_idle();
        id_set(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // Inputs change at posedge+1, outputs are checked at posedge+2.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        ex_redirect_i = 1'b0;
        mem_stall_i   = 1'b0;
        id_idle();
        tick();
        rst_i = 1'b0;
    endtask

    localparam logic [5:0] ADV    = 6'b110110;
    localparam logic [5:0] ADV_NV = 6'b110010;
    localparam logic [5:0] STALL  = 6'b000010;
    localparam logic [5:0] REDIR  = 6'b111010;
    localparam logic [5:0] FROZEN = 6'b000000;
    localparam logic [5:0] DRN    = 6'b011010;
    localparam logic [5:0] DRN_MS = 6'b001000;
    localparam logic [5:0] HALTD  = 6'b000001;

    initial begin
        rst_i         = 1'b1;
        ex_redirect_i = 1'b0;
        mem_stall_i   = 1'b0;
        id_idle();
        #2;
        chk("rst_out_f", 32'(f_out), 32'(FROZEN));
        chk("rst_out_n", 32'(n_out), 32'(FROZEN));
        tick();
        chk("rst_cnt_f", 32'(f_cnt), 0);
        chk("rst_cnt_n", 32'(n_cnt), 0);
        rst_i = 1'b0;

        // Load-use with forwarding: ld r1 ; add r2,r1,r3
        id_set(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        settle(); chk("lu_ld", 32'(f_out), 32'(ADV));
        tick();
        id_set(1, 3'd1, 1, 3'd3, 1, 1, 3'd2, 0, 0);
        settle(); chk("lu_stall", 32'(f_out), 32'(STALL));
        chk("lu_cnt0", 32'(f_cnt), 0);
        tick();
        settle(); chk("lu_issue", 32'(f_out), 32'(ADV));
        chk("lu_cnt1", 32'(f_cnt), 1);
        tick();
        id_idle();
        settle(); chk("lu_after", 32'(f_out), 32'(ADV_NV));
        chk("lu_cnt_hold", 32'(f_cnt), 1);

        // RAW without forwarding: add r1 ; add r4,r1,r1 ; add r6,r5,r5
        do_reset();
        id_set(1, 3'd2, 1, 3'd3, 1, 1, 3'd1, 0, 0);
        settle(); chk("raw_prod", 32'(n_out), 32'(ADV));
        tick();
        id_set(1, 3'd1, 1, 3'd1, 1, 1, 3'd4, 0, 0);
        settle(); chk("raw_st1", 32'(n_out), 32'(STALL));
        chk("raw_fwd_nostall", 32'(f_out), 32'(ADV));
        tick();
        settle(); chk("raw_st2", 32'(n_out), 32'(STALL));
        tick();
        settle(); chk("raw_issue", 32'(n_out), 32'(ADV));
        chk("raw_cnt2", 32'(n_cnt), 2);
        tick();
        id_set(1, 3'd5, 1, 3'd5, 1, 1, 3'd6, 0, 0);
        settle(); chk("raw_indep", 32'(n_out), 32'(ADV));
        tick();
        id_idle();
        settle(); chk("raw_cnt_final", 32'(n_cnt), 2);

        // Redirect coincident with a load-use hazard
        do_reset();
        id_set(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        tick();
        id_set(1, 3'd1, 1, 3'd3, 1, 1, 3'd2, 0, 0);
        ex_redirect_i = 1'b1;
        settle(); chk("rd_wins", 32'(f_out), 32'(REDIR));
        tick();
        ex_redirect_i = 1'b0;
        id_idle();
        settle(); chk("rd_after", 32'(f_out), 32'(ADV_NV));
        chk("rd_cnt", 32'(f_cnt), 0);

        // Memory stall held 4 cycles over a load-use hazard
        do_reset();
        id_set(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        tick();
        id_set(1, 3'd1, 1, 3'd3, 1, 1, 3'd2, 0, 0);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle(); chk($sformatf("ms_frz%0d", i), 32'(f_out), 32'(FROZEN));
            tick();
        end
        mem_stall_i = 1'b0;
        settle(); chk("ms_stall", 32'(f_out), 32'(STALL));
        chk("ms_cnt0", 32'(f_cnt), 0);
        tick();
        settle(); chk("ms_issue", 32'(f_out), 32'(ADV));
        chk("ms_cnt1", 32'(f_cnt), 1);

        // HALT drain with a stalled cycle and an ignored redirect
        do_reset();
        id_set(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
        settle(); chk("h_issue", 32'(f_out), 32'(ADV));
        tick();
        id_idle();
        ex_redirect_i = 1'b1;
        settle(); chk("h_d1_redir", 32'(f_out), 32'(DRN));
        tick();
        ex_redirect_i = 1'b0;
        mem_stall_i   = 1'b1;
        settle(); chk("h_d_memst", 32'(f_out), 32'(DRN_MS));
        tick();
        mem_stall_i = 1'b0;
        settle(); chk("h_d2", 32'(f_out), 32'(DRN));
        tick();
        settle(); chk("h_d3", 32'(f_out), 32'(DRN));
        tick();
        settle(); chk("h_halted", 32'(f_out), 32'(HALTD));
        tick();
        ex_redirect_i = 1'b1;
        id_set(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 0, 0);
        settle(); chk("h_stays", 32'(f_out), 32'(HALTD));
        tick();
        ex_redirect_i = 1'b0;
        id_idle();

        // Reset during DRAIN after one counted stall
        do_reset();
        id_set(1, 3'd0, 0, 3'd0, 0, 1, 3'd1, 1, 0);
        tick();
        id_set(1, 3'd1, 1, 3'd3, 1, 1, 3'd2, 0, 0);
        tick();
        tick();
        id_set(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
        settle(); chk("rd_pre_cnt", 32'(f_cnt), 1);
        tick();
        id_idle();
        settle(); chk("rd_in_drain", 32'(f_out), 32'(DRN));
        rst_i = 1'b1;
        settle(); chk("rd_rst_out", 32'(f_out), 32'(FROZEN));
        tick();
        rst_i = 1'b0;
        settle(); chk("rd_run", 32'(f_out), 32'(ADV_NV));
        chk("rd_cnt_clr", 32'(f_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
